truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_pkg.sv | 14 +
 rtl/truth_table_sweeper_if.sv | 38 +++
 rtl/truth_table_sweeper_settle_timer.sv | 48 ++++
 rtl/truth_table_sweeper.sv | 151 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// Optional stability checking is enabled with TT_STABILITY_CHECK_EN.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_DONE
    } tt_state_e;

    localparam int NUM_VEC = 8;
    localparam int IDX_W   = 3;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/status and gate-side signals of the truth-table sweeper.
// The unstable flag exists only when TT_STABILITY_CHECK_EN is defined.
interface truth_table_sweeper_if;

    logic       start;
    logic       stim_in1;
    logic       stim_in2;
    logic       stim_in3;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;
`ifdef TT_STABILITY_CHECK_EN
    logic       unstable;

    modport master (
        output start, dut_out,
        input  stim_in1, stim_in2, stim_in3, busy, done, table_out, match, unstable
    );

    modport slave (
        input  start, dut_out,
        output stim_in1, stim_in2, stim_in3, busy, done, table_out, match, unstable
    );
`else
    modport master (
        output start, dut_out,
        input  stim_in1, stim_in2, stim_in3, busy, done, table_out, match
    );

    modport slave (
        input  start, dut_out,
        output stim_in1, stim_in2, stim_in3, busy, done, table_out, match
    );
`endif

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Per-vector settle counter: counts 0..SETTLE and holds at SETTLE until restarted.
// late_window (TT_STABILITY_CHECK_EN only) marks the final ceil(SETTLE/2) settle cycles.
module settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
`ifdef TT_STABILITY_CHECK_EN
    output logic late_window,
`endif
    output logic expire
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (count != CNT_W'(SETTLE)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == CNT_W'(SETTLE - 1));

`ifdef TT_STABILITY_CHECK_EN
    localparam int LATE_LO = SETTLE - (SETTLE + 1) / 2;

    // Count 0 is excluded: its previous cycle still carried the prior vector.
    function automatic logic [SETTLE:0] late_mask();
        logic [SETTLE:0] m;
        for (int i = 0; i <= SETTLE; i++) begin
            m[i] = (i >= LATE_LO) && (i < SETTLE) && (i != 0);
        end
        return m;
    endfunction

    localparam logic [SETTLE:0] LATE_MASK = late_mask();

    assign late_window = LATE_MASK[count];
`endif

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 input vectors into a 3-input gate, samples its output after a settle
// window and compares the measured table to EXPECTED. Option: TT_STABILITY_CHECK_EN.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int                 SETTLE   = 4,
    parameter logic [NUM_VEC-1:0] EXPECTED = 8'hA0
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_sweeper_if.slave tt
);

    generate
        if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
            $error("truth_table_sweeper: SETTLE must be in 1..255");
        end
    endgenerate

    tt_state_e          state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   stim;
    logic               pend;
    logic [NUM_VEC-1:0] table_q;
    logic               match_q;
    logic               busy_q;
    logic               done_q;
    logic               restart;
    logic               expire;
    logic               change;
    logic               last_vec;

    assign last_vec = (idx == IDX_W'(NUM_VEC - 1));
    assign restart  = ((state == ST_IDLE) && tt.start) || ((state == ST_APPLY) && pend);

`ifdef TT_STABILITY_CHECK_EN
    logic late_window;
    logic prev_out;
    logic unstable_q;

    assign change = (state == ST_APPLY) && late_window && (tt.dut_out != prev_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_out <= 1'b0;
        end else begin
            prev_out <= tt.dut_out;
        end
    end

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .late_window (late_window),
        .expire      (expire)
    );

    assign tt.unstable = unstable_q;
`else
    assign change = 1'b0;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .expire  (expire)
    );
`endif

    // Each vector occupies SETTLE+1 cycles: sample at count SETTLE-1, advance one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            stim    <= '0;
            pend    <= 1'b0;
            table_q <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TT_STABILITY_CHECK_EN
            unstable_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tt.start) begin
                        state   <= ST_APPLY;
                        idx     <= '0;
                        stim    <= '0;
                        pend    <= 1'b0;
                        table_q <= '0;
                        match_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef TT_STABILITY_CHECK_EN
                        unstable_q <= 1'b0;
`endif
                    end
                end
                ST_APPLY: begin
`ifdef TT_STABILITY_CHECK_EN
                    if (change) begin
                        unstable_q <= 1'b1;
                    end
`endif
                    if (pend) begin
                        pend <= 1'b0;
                        if (last_vec) begin
                            state  <= ST_DONE;
                            stim   <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            idx  <= idx + 1'b1;
                            stim <= idx + 1'b1;
                        end
                    end else if (expire) begin
                        table_q[idx] <= tt.dut_out;
                        pend         <= 1'b1;
                        if (last_vec) begin
`ifdef TT_STABILITY_CHECK_EN
                            match_q <= ({tt.dut_out, table_q[NUM_VEC-2:0]} == EXPECTED)
                                       && !(unstable_q || change);
`else
                            match_q <= ({tt.dut_out, table_q[NUM_VEC-2:0]} == EXPECTED)
                                       && !change;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tt.stim_in1  = stim[2];
    assign tt.stim_in2  = stim[1];
    assign tt.stim_in3  = stim[0];
    assign tt.busy      = busy_q;
    assign tt.done      = done_q;
    assign tt.table_out = table_q;
    assign tt.match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: SETTLE=4/EXPECTED=A0 and SETTLE=1/EXPECTED=FF instances, each
// driven by a table-lookup gate model, with a scoreboard of expected sweep results.
module tb_truth_table_sweeper;

    localparam logic [7:0] EXP_A = 8'hA0;
    localparam logic [7:0] EXP_B = 8'hFF;

    typedef struct {
        logic [7:0] tbl;
        logic       mt;
        logic       un;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   done_cyc_a[$];

    logic [7:0] gate_a = 8'h00;
    logic [7:0] gate_b = 8'h00;
    logic       glitch_a = 1'b0;

    truth_table_sweeper_if ifa ();
    truth_table_sweeper_if ifb ();

    truth_table_sweeper #(.SETTLE(4), .EXPECTED(EXP_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .tt  (ifa.slave)
    );

    truth_table_sweeper #(.SETTLE(1), .EXPECTED(EXP_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .tt  (ifb.slave)
    );

    wire [2:0] stim_a = {ifa.stim_in1, ifa.stim_in2, ifa.stim_in3};
    wire [2:0] stim_b = {ifb.stim_in1, ifb.stim_in2, ifb.stim_in3};

    assign ifa.dut_out = gate_a[stim_a] ^ glitch_a;
    assign ifb.dut_out = gate_b[stim_b];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] stim_of(input int sel);
        return (sel != 0) ? stim_b : stim_a;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? ifb.busy : ifa.busy;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel != 0) ? ifb.done : ifa.done;
    endfunction

    // Scoreboard consumers: one pop per done pulse.
    always @(negedge clk) begin
        if (ifa.done) begin
            done_cyc_a.push_back(cyc);
            if (sb_a.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                chk("a_table", ifa.table_out, e.tbl);
                chk("a_match", ifa.match, e.mt);
`ifdef TT_STABILITY_CHECK_EN
                chk("a_unstable", ifa.unstable, e.un);
`endif
            end
        end
        if (ifb.done) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                chk("b_table", ifb.table_out, e.tbl);
                chk("b_match", ifb.match, e.mt);
`ifdef TT_STABILITY_CHECK_EN
                chk("b_unstable", ifb.unstable, e.un);
`endif
            end
        end
    end

    function automatic exp_t make_exp(input logic [7:0] tbl, input logic [7:0] ref_tbl,
                                      input logic glitchy);
        exp_t e;
        e.tbl = tbl;
        e.un  = glitchy;
`ifdef TT_STABILITY_CHECK_EN
        e.mt  = (tbl == ref_tbl) && !glitchy;
`else
        e.mt  = (tbl == ref_tbl);
`endif
        return e;
    endfunction

    // One full sweep with per-vector timing checks; glitch_cyc < 0 means no glitch.
    task automatic sweep(input int sel, input logic [7:0] tbl, input int glitch_cyc);
        int s;
        int len;
        s   = (sel != 0) ? 1 : 4;
        len = 8 * (s + 1);
        @(negedge clk);
        if (sel != 0) begin
            gate_b = tbl;
            sb_b.push_back(make_exp(tbl, EXP_B, 1'b0));
            ifb.start = 1'b1;
        end else begin
            gate_a = tbl;
            sb_a.push_back(make_exp(tbl, EXP_A, glitch_cyc >= 0));
            ifa.start = 1'b1;
        end
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (sel == 0) glitch_a = (c == glitch_cyc);
            if (c % (s + 1) == 0) begin
                chk("stim_step", stim_of(sel), c / (s + 1));
                chk("busy_in_sweep", busy_of(sel), 1);
            end
            if (c == len - 1) chk("done_not_early", done_of(sel), 0);
            @(posedge clk);
            #1;
        end
        glitch_a = 1'b0;
        chk("done_at_latency", done_of(sel), 1);
        chk("busy_fall", busy_of(sel), 0);
        chk("stim_idle_in_done", stim_of(sel), 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done_of(sel), 0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        #1;
        chk("rst_stim", stim_a, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_table", ifa.table_out, 0);
        chk("rst_match", ifa.match, 0);
        chk("rst_b_busy", ifb.busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        sweep(0, 8'hA0, -1);
        sweep(0, 8'h5F, -1);

        // Reset at vector 3 of a sweep whose table already has set bits.
        @(negedge clk);
        gate_a = 8'hFF;
        sb_a.push_back(make_exp(8'hFF, EXP_A, 1'b0));
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        chk("pre_rst_partial", ifa.table_out, 8'h07);
        rst = 1'b1;
        sb_a.delete();
        #1;
        chk("midrst_stim", stim_a, 0);
        chk("midrst_busy", ifa.busy, 0);
        chk("midrst_done", ifa.done, 0);
        chk("midrst_table", ifa.table_out, 0);
        chk("midrst_match", ifa.match, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep(0, 8'hA0, -1);

        // start held high: back-to-back sweeps accepted only from IDLE.
        @(negedge clk);
        done_cyc_a.delete();
        gate_a = 8'hA0;
        for (int i = 0; i < 3; i++) sb_a.push_back(make_exp(8'hA0, EXP_A, 1'b0));
        ifa.start = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk("b2b_done_count", done_cyc_a.size(), 3);
        if (done_cyc_a.size() == 3) begin
            chk("b2b_gap1", done_cyc_a[1] - done_cyc_a[0], 42);
            chk("b2b_gap2", done_cyc_a[2] - done_cyc_a[1], 42);
        end
        chk("b2b_idle_after", ifa.busy, 0);

        sweep(1, 8'hFF, -1);
        sweep(1, 8'h0F, -1);

`ifdef TT_STABILITY_CHECK_EN
        sweep(0, 8'hA0, 27);
        chk("unstable_held", ifa.unstable, 1);
        sweep(0, 8'hA0, -1);
        chk("unstable_cleared", ifa.unstable, 0);
`endif

        repeat (3) @(posedge clk);
        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
